// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared constants, state encoding and the stall-priority helper
//               for the pipeline stall/flush sequencer.
// Contents    : STOP/NO_STOP stage-hold levels, RST_ENABLE, ZERO_WORD,
//               EXC_ERET exception code, ctrl_state_e (CTRL_IDLE/CTRL_FLUSH),
//               stall_vector() request-to-vector mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

  localparam logic        STOP       = 1'b1;
  localparam logic        NO_STOP    = 1'b0;
  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET   = 32'h0000_000e;

  typedef enum logic [0:0] {
    CTRL_IDLE  = 1'b0,
    CTRL_FLUSH = 1'b1
  } ctrl_state_e;

  // A request from a later stage must also hold every earlier stage, so the
  // deepest requester decides how far the hold reaches (mem > ex > id).
  function automatic logic [5:0] stall_vector(input logic req_id,
                                              input logic req_ex,
                                              input logic req_mem);
    if (req_mem)     return {NO_STOP, {5{STOP}}};
    else if (req_ex) return {{2{NO_STOP}}, {4{STOP}}};
    else if (req_id) return {{3{NO_STOP}}, {3{STOP}}};
    else             return {6{NO_STOP}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_perf_cnt
// Description : 32-bit event counter with enable; wraps modulo 2^32.
// Ports       : clk   in  1   clock
//               rst   in  1   synchronous reset, active-high
//               en    in  1   count this cycle
//               count out 32  current count
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_perf_cnt
  import pipeline_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] count
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_count <= ZERO_WORD;
    end else if (en) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stall/flush sequencer for the 6-stage pipeline
//               (pc, if, id, ex, mem, wb). Merges stall requests, drives the
//               per-stage hold vector, runs a multi-cycle flush on exceptions
//               with PC redirect, and watches for a hung data bus.
// Config      : CTRL_PERF_CNT_EN - when defined, stall_cnt/flush_cnt are real
//               counters; otherwise both ports read zero.
// Ports       : clk, rst (sync, active-high)
//               stallreq_from_id/ex/mem  in   stage hold requests
//               excepttype_i             in   mem-stage exception code, 0=none
//               cp0_epc_i                in   EPC for eret
//               stall[5:0]               out  [0]=pc .. [5]=wb hold
//               flush                    out  clear all pipeline registers
//               new_pc[31:0]             out  redirect target while flush=1
//               bus_timeout              out  one-cycle watchdog pulse
//               stall_cnt, flush_cnt     out  performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        bus_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam int WDOG_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  ctrl_state_e       r_state, w_state_next;
  logic [FCNT_W-1:0] r_fcnt, w_fcnt_next;
  logic [31:0]       r_new_pc, w_new_pc_next;
  logic [WDOG_W-1:0] r_wdog, w_wdog_next, w_wdog_inc;
  logic [31:0]       w_exc_target;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state  <= CTRL_IDLE;
      r_fcnt   <= '0;
      r_new_pc <= ZERO_WORD;
      r_wdog   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_fcnt   <= w_fcnt_next;
      r_new_pc <= w_new_pc_next;
      r_wdog   <= w_wdog_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_fcnt_next   = r_fcnt;
    w_new_pc_next = r_new_pc;
    w_wdog_next   = r_wdog;
    w_wdog_inc    = r_wdog + 1'b1;
    w_exc_target  = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
    stall         = '0;
    flush         = 1'b0;
    new_pc        = r_new_pc;
    bus_timeout   = 1'b0;

    // Outputs are held quiet in the reset cycle so nothing downstream sees a
    // flush or hold triggered by stale inputs while the core is resetting.
    if (rst != RST_ENABLE) begin
      case (r_state)
        CTRL_IDLE: begin
          if (excepttype_i != ZERO_WORD) begin
            // Exception wins over any stall request; redirect is visible in
            // the same cycle and captured for the remaining flush cycles.
            flush         = 1'b1;
            new_pc        = w_exc_target;
            w_new_pc_next = w_exc_target;
            w_wdog_next   = '0;
            if (FLUSH_CYCLES > 1) begin
              w_state_next = CTRL_FLUSH;
              w_fcnt_next  = FCNT_W'(FLUSH_CYCLES - 1);
            end
          end else begin
            stall = stall_vector(stallreq_from_id, stallreq_from_ex,
                                 stallreq_from_mem);
            if (stallreq_from_mem) begin
              // Pulse on the cycle the run length hits TIMEOUT and restart,
              // so a bus that stays stuck keeps pulsing every TIMEOUT cycles.
              if (w_wdog_inc == WDOG_W'(TIMEOUT)) begin
                bus_timeout = 1'b1;
                w_wdog_next = '0;
              end else begin
                w_wdog_next = w_wdog_inc;
              end
            end else begin
              w_wdog_next = '0;
            end
          end
        end
        CTRL_FLUSH: begin
          // All requests and further exceptions are ignored while flushing.
          flush       = 1'b1;
          w_wdog_next = '0;
          w_fcnt_next = r_fcnt - 1'b1;
          if (r_fcnt == FCNT_W'(1)) begin
            w_state_next = CTRL_IDLE;
          end
        end
        default: begin
          w_state_next = CTRL_IDLE;
        end
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  ctrl_perf_cnt u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall != 6'b000000),
    .count (stall_cnt)
  );

  // Count exception entries only, not every cycle that flush is high.
  ctrl_perf_cnt u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (flush && (r_state == CTRL_IDLE)),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = ZERO_WORD;
  assign flush_cnt = ZERO_WORD;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl (FLUSH_CYCLES=3,
//               TIMEOUT=4). Directed scenarios followed by random traffic,
//               all compared against a cycle-level behavioural model.
// Config      : CTRL_PERF_CNT_EN selects whether counters are expected live.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int          FC  = 3;
  localparam int          TO  = 4;
  localparam logic [31:0] VEC = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_id, req_ex, req_mem;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        bus_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  int          m_flush_left;
  logic [31:0] m_pc;
  int          m_mem_run;
  logic [31:0] m_stall_cnt, m_flush_cnt;

  pipeline_ctrl #(
    .EXC_VECTOR   (VEC),
    .FLUSH_CYCLES (FC),
    .TIMEOUT      (TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_id  (req_id),
    .stallreq_from_ex  (req_ex),
    .stallreq_from_mem (req_mem),
    .excepttype_i      (exc),
    .cp0_epc_i         (epc),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .bus_timeout       (bus_timeout),
    .stall_cnt         (stall_cnt),
    .flush_cnt         (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef CTRL_PERF_CNT_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic cyc(input logic r, input logic i, input logic e,
                     input logic m, input logic [31:0] x,
                     input logic [31:0] p, input string tag);
    logic [5:0]  e_stall;
    logic        e_flush, e_bt, take;
    logic [31:0] e_pc;
    rst = r; req_id = i; req_ex = e; req_mem = m; exc = x; epc = p;
    #4;
    e_stall = 6'b0; e_flush = 1'b0; e_bt = 1'b0; e_pc = m_pc; take = 1'b0;
    if (!r) begin
      if (m_flush_left > 0) begin
        e_flush = 1'b1;
      end else if (x != 32'h0) begin
        e_flush = 1'b1;
        e_pc    = (x == 32'h0000_000e) ? p : VEC;
        take    = 1'b1;
      end else begin
        e_stall = m ? 6'b011111 : e ? 6'b001111 : i ? 6'b000111 : 6'b000000;
        e_bt    = m && (m_mem_run + 1 == TO);
      end
      check32({tag, ".stall_cnt"}, stall_cnt, perf(m_stall_cnt));
      check32({tag, ".flush_cnt"}, flush_cnt, perf(m_flush_cnt));
      if (e_flush) check32({tag, ".new_pc"}, new_pc, e_pc);
    end
    check32({tag, ".stall"}, {26'b0, stall}, {26'b0, e_stall});
    check32({tag, ".flush"}, {31'b0, flush}, {31'b0, e_flush});
    check32({tag, ".bus_timeout"}, {31'b0, bus_timeout}, {31'b0, e_bt});
    @(posedge clk);
    #1;
    if (r) begin
      m_flush_left = 0; m_pc = 32'h0; m_mem_run = 0;
      m_stall_cnt = 32'h0; m_flush_cnt = 32'h0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      m_mem_run = 0;
    end else if (take) begin
      m_pc = e_pc; m_flush_left = FC - 1; m_mem_run = 0;
      m_flush_cnt = m_flush_cnt + 32'd1;
    end else begin
      if (e_stall != 6'b0) m_stall_cnt = m_stall_cnt + 32'd1;
      if (m) m_mem_run = e_bt ? 0 : m_mem_run + 1;
      else   m_mem_run = 0;
    end
  endtask

  initial begin
    logic [31:0] rx;
    m_flush_left = 0; m_pc = 32'h0; m_mem_run = 0;
    m_stall_cnt = 32'h0; m_flush_cnt = 32'h0;
    rst = 1'b1; req_id = 1'b0; req_ex = 1'b0; req_mem = 1'b0;
    exc = 32'h0; epc = 32'h0;
    @(posedge clk);
    #1;

    // Reset state
    cyc(1, 0, 0, 0, 32'h0, 32'h0, "rst");
    cyc(1, 0, 0, 0, 32'h0, 32'h0, "rst");
    cyc(0, 0, 0, 0, 32'h0, 32'h0, "idle");
    check32("reset.new_pc", new_pc, 32'h0);

    // ex busy two cycles, then release
    cyc(0, 0, 1, 0, 32'h0, 32'h0, "t1a");
    cyc(0, 0, 1, 0, 32'h0, 32'h0, "t1b");
    cyc(0, 0, 0, 0, 32'h0, 32'h0, "t1c");

    // all three requests, then mem drops
    cyc(0, 1, 1, 1, 32'h0, 32'h0, "t2a");
    cyc(0, 1, 1, 0, 32'h0, 32'h0, "t2b");
    cyc(0, 1, 0, 0, 32'h0, 32'h0, "t2c");

    // exception beats mem stall; flush lasts FC cycles
    cyc(0, 0, 0, 1, 32'h1, 32'h0, "t3a");
    cyc(0, 0, 0, 1, 32'h0, 32'h0, "t3b");
    cyc(0, 0, 0, 0, 32'h0, 32'h0, "t3c");
    cyc(0, 0, 0, 0, 32'h0, 32'h0, "t3d");

    // eret to EPC; second exception during flush ignored
    cyc(0, 0, 0, 0, 32'he, 32'h1234, "t4a");
    cyc(0, 0, 0, 0, 32'h1, 32'h0, "t4b");
    cyc(0, 1, 0, 0, 32'h5, 32'h0, "t4c");
    cyc(0, 0, 0, 0, 32'h0, 32'h0, "t4d");

    // watchdog: 10 mem-stall cycles, pulses on 4th and 8th
    for (int k = 1; k <= 10; k++) cyc(0, 0, 0, 1, 32'h0, 32'h0, $sformatf("t5w%0d", k));
    cyc(0, 0, 0, 0, 32'h0, 32'h0, "t5x");

    // reset in the middle of a flush
    cyc(0, 0, 0, 0, 32'h3, 32'h0, "t5f");
    cyc(0, 0, 0, 0, 32'h0, 32'h0, "t5g");
    cyc(1, 0, 0, 0, 32'h0, 32'h0, "t5r");
    cyc(0, 0, 0, 0, 32'h0, 32'h0, "t5h");

    // perf counters: 5 stall cycles + 2 exceptions
    cyc(1, 0, 0, 0, 32'h0, 32'h0, "t6r");
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0, 32'h0, 32'h0, "t6s");
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 0, 32'h7, 32'h0, "t6e");
      cyc(0, 0, 0, 0, 32'h0, 32'h0, "t6f");
      cyc(0, 0, 0, 0, 32'h0, 32'h0, "t6f");
    end
    cyc(0, 0, 0, 0, 32'h0, 32'h0, "t6z");
`ifdef CTRL_PERF_CNT_EN
    check32("t6.stall_cnt", stall_cnt, 32'd5);
    check32("t6.flush_cnt", flush_cnt, 32'd2);
`else
    check32("t6.stall_cnt", stall_cnt, 32'd0);
    check32("t6.flush_cnt", flush_cnt, 32'd0);
`endif

    // random traffic
    cyc(1, 0, 0, 0, 32'h0, 32'h0, "rnd_rst");
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 11) == 0)
        rx = ($urandom_range(0, 1) == 0) ? 32'h0000_000e : 32'($urandom_range(1, 31));
      else
        rx = 32'h0;
      cyc(($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
          rx, $urandom, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
